// File: rtl/dpu_pkg.sv
// Shared DPU definitions: command encoding used by the loader and the DPU top.
package dpu_pkg;

  typedef enum logic [1:0] {
    CMD_WRITE = 2'd0,
    CMD_RUN   = 2'd1,
    CMD_READ  = 2'd2
  } cmd_type_e;

endpackage

// File: rtl/dpu_pad_coord_cnt.sv
// Channel/row/column walk over the padded image with a running linear address,
// plus border and last-position flags for the current coordinate.
module dpu_pad_coord_cnt #(
  parameter int PAD_H     = 418,
  parameter int PAD_W     = 418,
  parameter int NUM_IN_CH = 3,
  parameter int PAD_SIZE  = NUM_IN_CH * PAD_H * PAD_W,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 adv,
  output logic [ADDR_BITS-1:0] addr,
  output logic                 border,
  output logic                 last
);
  import dpu_pkg::*;

  localparam int CW = (NUM_IN_CH > 1) ? $clog2(NUM_IN_CH) : 1;
  localparam int YW = $clog2(PAD_H);
  localparam int XW = $clog2(PAD_W);

  logic [CW-1:0] c_q;
  logic [YW-1:0] y_q;
  logic [XW-1:0] x_q;

  // Address is linear in (c, y, x) order, so a plain increment tracks it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_q  <= '0;
      y_q  <= '0;
      x_q  <= '0;
      addr <= '0;
    end else if (clr) begin
      c_q  <= '0;
      y_q  <= '0;
      x_q  <= '0;
      addr <= '0;
    end else if (adv) begin
      addr <= addr + ADDR_BITS'(1);
      if (x_q == XW'(PAD_W - 1)) begin
        x_q <= '0;
        if (y_q == YW'(PAD_H - 1)) begin
          y_q <= '0;
          c_q <= c_q + CW'(1);
        end else begin
          y_q <= y_q + YW'(1);
        end
      end else begin
        x_q <= x_q + XW'(1);
      end
    end
  end

  assign border = (y_q == '0) || (y_q == YW'(PAD_H - 1)) ||
                  (x_q == '0) || (x_q == XW'(PAD_W - 1));
  assign last   = (addr == ADDR_BITS'(PAD_SIZE - 1));

endmodule

// File: rtl/dpu_pad_loader.sv
// Streams an unpadded planar image into the DPU as byte-write commands,
// inserting a one-pixel zero border, optionally followed by a run command.
module dpu_pad_loader #(
  parameter int H_IN      = 416,
  parameter int W_IN      = 416,
  parameter int NUM_IN_CH = 3,
  parameter int ADDR_BITS = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 run_after,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [7:0]           s_data,
  output logic                 cmd_valid,
  input  logic                 cmd_ready,
  output logic [1:0]           cmd_type,
  output logic [ADDR_BITS-1:0] cmd_addr,
  output logic [7:0]           cmd_data,
  output logic                 busy,
  output logic                 done
);
  import dpu_pkg::*;

  localparam int PAD_H    = H_IN + 2;
  localparam int PAD_W    = W_IN + 2;
  localparam int PAD_SIZE = NUM_IN_CH * PAD_H * PAD_W;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_ADV, S_RUN, S_DONE
  } state_e;

  state_e                 state;
  logic                   run_after_q;
  logic [ADDR_BITS-1:0]   pos_addr;
  logic                   border;
  logic                   last;
  logic                   clr;
  logic                   adv;

  assign clr     = (state == S_IDLE) && start;
  assign adv     = (state == S_ADV) && !last;
  assign s_ready = (state == S_FETCH) && !border;

  dpu_pad_coord_cnt #(
    .PAD_H     (PAD_H),
    .PAD_W     (PAD_W),
    .NUM_IN_CH (NUM_IN_CH),
    .PAD_SIZE  (PAD_SIZE),
    .ADDR_BITS (ADDR_BITS)
  ) u_coord (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .adv    (adv),
    .addr   (pos_addr),
    .border (border),
    .last   (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      run_after_q <= 1'b0;
      cmd_valid   <= 1'b0;
      cmd_type    <= CMD_WRITE;
      cmd_addr    <= '0;
      cmd_data    <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            run_after_q <= run_after;
            busy        <= 1'b1;
            state       <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Border pixels are synthesized; interior pixels wait for the stream.
          if (border || s_valid) begin
            cmd_data  <= border ? 8'h00 : s_data;
            cmd_addr  <= pos_addr;
            cmd_type  <= CMD_WRITE;
            cmd_valid <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= S_ADV;
          end
        end
        S_ADV: begin
          if (!last) begin
            state <= S_FETCH;
          end else if (run_after_q) begin
            cmd_type  <= CMD_RUN;
            cmd_addr  <= '0;
            cmd_data  <= '0;
            cmd_valid <= 1'b1;
            state     <= S_RUN;
          end else begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_RUN: begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dpu_pad_loader.sv
// Bench for dpu_pad_loader on a 3x2x2 image: reference command list built from
// the padding rules, directed stall/reset cases and randomized handshakes.
module tb_dpu_pad_loader;
  import dpu_pkg::*;

  localparam int H_IN     = 2;
  localparam int W_IN     = 2;
  localparam int NCH      = 3;
  localparam int AB       = 24;
  localparam int PAD_H    = H_IN + 2;
  localparam int PAD_W    = W_IN + 2;
  localparam int PAD_SIZE = NCH * PAD_H * PAD_W;
  localparam int NBYTES   = NCH * H_IN * W_IN;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          run_after;
  logic          s_valid;
  logic          s_ready;
  logic [7:0]    s_data;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_type;
  logic [AB-1:0] cmd_addr;
  logic [7:0]    cmd_data;
  logic          busy;
  logic          done;

  dpu_pad_loader #(
    .H_IN(H_IN), .W_IN(W_IN), .NUM_IN_CH(NCH), .ADDR_BITS(AB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .run_after(run_after),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]    t;
    logic [AB-1:0] a;
    logic [7:0]    d;
  } cmd_t;

  cmd_t       got_q[$];
  cmd_t       exp_q[$];
  logic [7:0] img[NBYTES];
  int         consumed = 0;
  int         done_cnt = 0;
  int         n_cmp = 0;
  int         n_err = 0;
  bit         fin;
  int         g_base;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
    n_cmp++;
    if (obs !== req) begin
      n_err++;
      $display("FAIL %s: observed %0h required %0h", tag, obs, req);
    end
  endtask

  // Transfers are recorded half a cycle before the edge that performs them.
  always @(negedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) got_q.push_back({cmd_type, cmd_addr, cmd_data});
    if (rst_n && s_valid && s_ready) consumed <= consumed + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  function automatic void build_exp(input bit ra);
    int k;
    int a;
    logic [7:0] d;
    exp_q.delete();
    k = 0;
    a = 0;
    for (int c = 0; c < NCH; c++)
      for (int y = 0; y < PAD_H; y++)
        for (int x = 0; x < PAD_W; x++) begin
          if (y == 0 || y == PAD_H - 1 || x == 0 || x == PAD_W - 1) d = 8'h00;
          else begin
            d = img[k];
            k++;
          end
          exp_q.push_back({2'd0, AB'(a), d});
          a++;
        end
    if (ra) exp_q.push_back({2'd1, AB'(0), 8'h00});
  endfunction

  function automatic logic [63:0] last_addr(input int base);
    if (got_q.size() > base) return 64'(got_q[got_q.size()-1].a);
    return 64'hFFFF_FFFF;
  endfunction

  // modes: 0 free-run, 1 random handshakes, 2 cmd_ready hold at addr 5,
  // 3 s_valid gap at addr 5, 4 extra start pulses, 5 reset after addr 20
  task automatic feeder(input int mode);
    int  idx = 0;
    bit  stalled = 0;
    int  c0;
    while (!fin) begin
      @(posedge clk); #1;
      if (fin) break;
      if (idx >= NBYTES) begin
        s_valid = 1'b0;
        continue;
      end
      if (mode == 3 && idx == 0 && !stalled) begin
        s_valid = 1'b0;
        stalled = 1;
        @(negedge clk);
        for (int w = 0; w < 200 && !s_ready; w++) @(negedge clk);
        chk("gap_sready_up", s_ready, 1);
        chk("gap_prev_addr", last_addr(g_base), 4);
        c0 = consumed;
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("gap_sready_held", s_ready, 1);
        end
        chk("gap_no_consume", consumed, c0);
        continue;
      end
      s_valid = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      s_data  = img[idx];
      @(negedge clk);
      if (s_valid && s_ready) idx++;
    end
    s_valid = 1'b0;
  endtask

  task automatic ready_drv(input int mode);
    bit held = 0;
    int c0;
    while (!fin) begin
      @(posedge clk); #1;
      if (fin) break;
      if (mode == 2 && !held && cmd_valid && cmd_addr == AB'(5)) begin
        held = 1;
        cmd_ready = 1'b0;
        c0 = consumed;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          chk("hold_valid", cmd_valid, 1);
          chk("hold_addr", cmd_addr, 5);
          chk("hold_data", cmd_data, 1);
          chk("hold_sready", s_ready, 0);
        end
        chk("hold_no_consume", consumed, c0);
        cmd_ready = 1'b1;
        continue;
      end
      cmd_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    cmd_ready = 1'b1;
  endtask

  task automatic watcher(input int mode);
    for (int i = 0; i < 3000 && !fin; i++) begin
      @(negedge clk);
      start = (mode == 4 && (i == 20 || i == 60)) ? 1'b1 : 1'b0;
      if (done) fin = 1;
      if (mode == 5 && last_addr(g_base) == 20) begin
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_valid", cmd_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_sready", s_ready, 0);
        chk("rst_mid_addr", cmd_addr, 0);
        chk("rst_mid_done", done, 0);
        fin = 1;
      end
    end
    start = 1'b0;
    if (!fin) begin
      chk("timeout", 0, 1);
      fin = 1;
    end
  endtask

  task automatic run_image(input bit ra, input int mode);
    int cb;
    int db;
    int n;
    build_exp(ra);
    g_base = got_q.size();
    cb = consumed;
    db = done_cnt;
    fin = 0;
    @(posedge clk); #1;
    start = 1'b1;
    run_after = ra;
    @(posedge clk); #1;
    start = 1'b0;
    run_after = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy, 1);
    fork
      feeder(mode);
      ready_drv(mode);
      watcher(mode);
    join
    if (mode == 5) return;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n = got_q.size() - g_base;
    chk("cmd_count", n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk($sformatf("cmd_m%0d_%0d", mode, i), got_q[g_base + i], exp_q[i]);
    chk("done_pulses", done_cnt - db, 1);
    chk("bytes_consumed", consumed - cb, NBYTES);
    chk("busy_idle", busy, 0);
  endtask

  task automatic spot(input int a, input int d);
    int idx;
    idx = g_base + a;
    chk($sformatf("spot_addr%0d", a), (idx < got_q.size()) ? 64'(got_q[idx].d) : 64'h1FF, d);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    run_after = 1'b0;
    s_valid = 1'b0;
    s_data = 8'h00;
    cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_type", cmd_type, 0);
    chk("rst_addr", cmd_addr, 0);
    chk("rst_data", cmd_data, 0);
    chk("rst_sready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < NBYTES; i++) img[i] = 8'(i + 1);

    run_image(0, 0);
    spot(0, 0);  spot(5, 1);  spot(6, 2);  spot(9, 3);
    spot(10, 4); spot(21, 5); spot(42, 12); spot(47, 0);
    chk("last_write_addr", last_addr(g_base), PAD_SIZE - 1);

    run_image(1, 0);
    chk("run_cmd_type", (got_q.size() > 0) ? 64'(got_q[got_q.size()-1].t) : 64'h3, 1);
    chk("run_cmd_addr", last_addr(g_base), 0);

    run_image(0, 2);
    run_image(0, 3);

    run_image(0, 5);
    @(negedge clk);
    rst_n = 1'b1;
    run_image(0, 0);
    chk("restart_first_addr",
        (got_q.size() > g_base) ? 64'(got_q[g_base].a) : 64'hFFFF, 0);

    run_image(0, 4);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NBYTES; i++) img[i] = 8'($urandom_range(0, 255));
      run_image(1'($urandom_range(0, 1)), 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/dpu_pad_loader.md
DPU_PAD_LOADER -- requirements
Module: dpu_pad_loader

Interface
REQ-001 Parameter H_IN, default 416, unpadded input image height.
REQ-002 Parameter W_IN, default 416, unpadded input image width.
REQ-003 Parameter NUM_IN_CH, default 3, input channels.
REQ-004 Parameter ADDR_BITS, default 24, command address width.
REQ-005 Localparams SHALL be PAD_H=H_IN+2, PAD_W=W_IN+2, PAD_SIZE=NUM_IN_CH*PAD_H*PAD_W.
REQ-006 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-007 Port rst_n, input, 1, asynchronous active-low reset.
REQ-008 Port start, input, 1, begins one image load when sampled high in S_IDLE.
REQ-009 Port run_after, input, 1, sampled with start; if 1, a run command follows the last write.
REQ-010 Port s_valid / s_ready / s_data, input / output / input, 1 / 1 / 8: unpadded byte stream, planar order (channel, row, column).
REQ-011 Port cmd_valid, output, 1, command present.
REQ-012 Port cmd_ready, input, 1, downstream DPU accepts command.
REQ-013 Port cmd_type, output, 2, 0=write_byte, 1=run_layer0.
REQ-014 Port cmd_addr, output, ADDR_BITS, byte address.
REQ-015 Port cmd_data, output, 8, write byte.
REQ-016 Port busy, output, 1, high from start acceptance until the done pulse.
REQ-017 Port done, output, 1, one-cycle completion pulse.

Function
REQ-018 Block SHALL emit exactly PAD_SIZE write_byte commands, addr = c*PAD_H*PAD_W + y*PAD_W + x, with c, y, x incremented innermost x, then y, then c, starting from 0.
REQ-019 Border positions (y==0, y==PAD_H-1, x==0, x==PAD_W-1) SHALL write 8'h00 without consuming stream data.
REQ-020 Interior positions SHALL write the next stream byte; exactly NUM_IN_CH*H_IN*W_IN bytes are consumed per image.
REQ-021 FSM states: S_IDLE, S_FETCH, S_ISSUE, S_ADV, S_RUN, S_DONE.
REQ-022 S_IDLE: start=1 -> latch run_after, clear c/y/x, busy<=1, go S_FETCH; start is ignored in all other states.
REQ-023 S_FETCH: on a border position, load cmd_data=0 and go S_ISSUE; on an interior position, drive s_ready=1 combinationally, and when s_valid=1 latch s_data and go S_ISSUE; otherwise hold.
REQ-024 s_ready SHALL be 0 in every state other than S_FETCH-interior.
REQ-025 S_ISSUE: cmd_valid=1 with cmd_type, cmd_addr and cmd_data held stable; a transfer occurs on a cycle with cmd_valid&&cmd_ready; the FSM then goes S_ADV.
REQ-026 S_ADV: cmd_valid=0 for this one cycle (mandatory gap, since the DPU acks each command); advance the counters; after the last position go S_RUN if run_after is latched, else S_DONE; otherwise go S_FETCH.
REQ-027 S_RUN: cmd_type=1, cmd_addr=0, cmd_data=0, cmd_valid=1 until cmd_ready, then go S_DONE.
REQ-028 S_DONE: done=1 and busy=0 for one cycle, then go S_IDLE.
REQ-029 Minimum throughput SHALL be 3 cycles per write (S_FETCH, S_ISSUE, S_ADV) with cmd_ready and s_valid both held high.
REQ-030 The address SHALL be kept as a running counter, not a multiply; the final address SHALL be PAD_SIZE-1 and SHALL NOT wrap.

Reset
REQ-031 rst_n low SHALL asynchronously force S_IDLE, cmd_valid=0, cmd_type=0, cmd_addr=0, cmd_data=0, s_ready=0, busy=0, done=0, and clear the counters and latched run_after.
REQ-032 Reset mid-load SHALL abandon the image; the next start restarts at addr 0, and no partial state survives.

Structure
REQ-033 Shared package dpu_pkg SHALL hold the cmd_type enum (CMD_WRITE=0, CMD_RUN=1, CMD_READ=2), which is also used by the DPU top.
REQ-034 One sub-module dpu_pad_coord_cnt (c/y/x/addr counters with border, last flags) is natural; the FSM stays in dpu_pad_loader.

Verification (H_IN=2, W_IN=2, NUM_IN_CH=3 -> PAD_SIZE=48)
REQ-035 Stream 1..12, cmd_ready always 1, run_after=0 -> 48 writes; addr 0 -> 0, 5 -> 1, 6 -> 2, 9 -> 3, 10 -> 4, 21 -> 5, 42 -> 12, 47 -> 0; then done pulse, no run command.
REQ-036 Same stream with run_after=1 -> after the write to addr 47, one command with type=1, addr=0, then done.
REQ-037 cmd_ready held low 10 cycles during S_ISSUE at addr 5 -> cmd_addr=5 and cmd_data=1 stay stable, s_ready=0, and no byte is consumed.
REQ-038 s_valid low 8 cycles at the interior addr 5 -> the write to addr 4 completes, the block stalls with s_ready=1, and it resumes at addr 5 with the correct byte.
REQ-039 rst_n asserted after the write to addr 20, then a new start with stream 1..12 -> the first command is addr 0, data 0, and the full 48-write sequence matches REQ-035.
REQ-040 start pulsed while busy -> ignored; exactly one done pulse and 48 writes.
